// File: rtl/dsp_branch_unit_pkg.sv
// rtl/dsp_branch_unit_pkg.sv - shared flow-control encodings and FSM states for the branch unit
package dsp_branch_unit_pkg;

  localparam int FLOW_W = 4;

  localparam logic [FLOW_W-1:0] FLOW_NONE = 4'd0;
  localparam logic [FLOW_W-1:0] FLOW_JMP  = 4'd1;
  localparam logic [FLOW_W-1:0] FLOW_BEZ  = 4'd2;
  localparam logic [FLOW_W-1:0] FLOW_BNEZ = 4'd3;
  localparam logic [FLOW_W-1:0] FLOW_BEQ  = 4'd4;
  localparam logic [FLOW_W-1:0] FLOW_BLTZ = 4'd5;
  localparam logic [FLOW_W-1:0] FLOW_CALL = 4'd6;
  localparam logic [FLOW_W-1:0] FLOW_RET  = 4'd7;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } bu_state_t;

endpackage

// File: rtl/dsp_ras.sv
// rtl/dsp_ras.sv - circular return-address stack with wrap-on-full and sticky error flags
module dsp_ras #(
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_data,
  output logic [ADDR_W-1:0] top_data,
  output logic [LVL_W-1:0]  level,
  output logic              empty,
  output logic              overflow,
  output logic              underflow
);

  logic [ADDR_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_ptr;
  logic [LVL_W-1:0]  r_level;
  logic              r_overflow;
  logic              r_underflow;
  logic [PTR_W-1:0]  w_top_idx;
  logic              w_full;

  // The pointer always addresses the next free slot, so the top entry sits one below it
  assign w_top_idx = r_ptr - PTR_W'(1);
  assign w_full    = (r_level == LVL_W'(DEPTH));
  assign empty     = (r_level == '0);
  assign top_data  = r_mem[w_top_idx];
  assign level     = r_level;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;

  // Entry storage needs no reset: an entry is only read after it has been pushed
  always_ff @(posedge clk) begin
    if (push) begin
      r_mem[r_ptr] <= push_data;
    end
  end

  // Pointer, occupancy and sticky flags; a push when full overwrites the oldest entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr       <= '0;
      r_level     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (push) begin
      r_ptr <= r_ptr + PTR_W'(1);
      if (w_full) begin
        r_overflow <= 1'b1;
      end else begin
        r_level <= r_level + LVL_W'(1);
      end
    end else if (pop) begin
      if (empty) begin
        r_underflow <= 1'b1;
      end else begin
        r_ptr   <= w_top_idx;
        r_level <= r_level - LVL_W'(1);
      end
    end
  end

endmodule

// File: rtl/dsp_branch_unit.sv
// rtl/dsp_branch_unit.sv - branch resolution, registered redirect, flush window and RAS control
module dsp_branch_unit
  import dsp_branch_unit_pkg::*;
#(
  parameter int DATA_W       = 16,
  parameter int ADDR_W       = 16,
  parameter int RAS_DEPTH    = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         valid_in,
  input  logic [FLOW_W-1:0]            flow_mode,
  input  logic [DATA_W-1:0]            alu_result,
  input  logic [ADDR_W-1:0]            address,
  input  logic [ADDR_W-1:0]            pc_next,
  output logic [ADDR_W-1:0]            jump_addr,
  output logic                         jump_flag,
  output logic                         flush,
  output logic                         ras_overflow,
  output logic                         ras_underflow,
  output logic [$clog2(RAS_DEPTH):0]   ras_level
);

  localparam int CNT_W = $clog2(FLUSH_CYCLES) + 1;

  bu_state_t         r_state;
  bu_state_t         w_state_nxt;
  logic [CNT_W-1:0]  r_flush_cnt;
  logic [ADDR_W-1:0] r_jump_addr;
  logic              r_jump_flag;

  logic              w_decide;
  logic              w_taken;
  logic              w_push;
  logic              w_pop;
  logic [ADDR_W-1:0] w_target;
  logic [ADDR_W-1:0] w_ras_top;
  logic              w_ras_empty;

  // Instructions arriving while the pipeline is being killed are ignored entirely
  assign w_decide = valid_in && (r_state == ST_IDLE);

  // Condition evaluation and RAS request generation for the instruction in decode
  always_comb begin
    w_taken  = 1'b0;
    w_target = address;
    w_push   = 1'b0;
    w_pop    = 1'b0;
    if (w_decide) begin
      case (flow_mode)
        FLOW_NONE: w_taken = 1'b0;
        FLOW_JMP:  w_taken = 1'b1;
        FLOW_BEZ:  w_taken = (alu_result == '0);
        FLOW_BNEZ: w_taken = (alu_result != '0);
        FLOW_BEQ:  w_taken = (alu_result == '0);
        FLOW_BLTZ: w_taken = alu_result[DATA_W-1];
        FLOW_CALL: begin
          w_taken = 1'b1;
          w_push  = 1'b1;
        end
        FLOW_RET: begin
          w_pop    = 1'b1;
          w_taken  = !w_ras_empty;
          w_target = w_ras_top;
        end
        default:   w_taken = 1'b0;
      endcase
    end
  end

  dsp_ras #(
    .ADDR_W (ADDR_W),
    .DEPTH  (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst_n     (rst),
    .push      (w_push),
    .pop       (w_pop),
    .push_data (pc_next),
    .top_data  (w_ras_top),
    .level     (ras_level),
    .empty     (w_ras_empty),
    .overflow  (ras_overflow),
    .underflow (ras_underflow)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: a taken redirect opens the kill window, the counter closes it
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_taken) w_state_nxt = ST_FLUSH;
      ST_FLUSH: if (r_flush_cnt == '0) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Down-counter holding the remaining flush cycles after the current one
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_flush_cnt <= '0;
    end else if (w_taken) begin
      r_flush_cnt <= CNT_W'(FLUSH_CYCLES - 1);
    end else if ((r_state == ST_FLUSH) && (r_flush_cnt != '0)) begin
      r_flush_cnt <= r_flush_cnt - CNT_W'(1);
    end
  end

  // Registered one-cycle redirect; the address holds between redirects
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_jump_flag <= 1'b0;
      r_jump_addr <= '0;
    end else begin
      r_jump_flag <= w_taken;
      if (w_taken) begin
        r_jump_addr <= w_target;
      end
    end
  end

  assign jump_flag = r_jump_flag;
  assign jump_addr = r_jump_addr;
  assign flush     = (r_state == ST_FLUSH);

endmodule

// File: doc/dsp_branch_unit.md
Name: dsp_branch_unit

Overview:
Parametrised next-generation branch unit for the DSP core. It resolves flow-control instructions from the decode-stage mode, target address and ALU result. It drives a registered redirect (jump_addr/jump_flag) to fetch, a pipeline-kill window (flush) to decode/execute, and keeps a hardware return-address stack (RAS) for CALL/RET. It sits between the ALU/decode outputs and the fetch block.

Parameters:
DATA_W, 16, ALU result width
ADDR_W, 16, instruction address width
RAS_DEPTH, 4, return-address stack entries (power of two, >=2)
FLUSH_CYCLES, 2, cycles of pipeline kill after a taken redirect (>=1)

Ports:
clk  in  1  core clock, rising edge
rst  in  1  asynchronous, active-low reset
valid_in  in  1  flow_mode/address/alu_result/pc_next are valid this cycle
flow_mode  in  4  flow-control opcode (encodings in shared package)
alu_result  in  DATA_W  condition value from ALU (subtract result for BEQ)
address  in  ADDR_W  branch/call target from decode
pc_next  in  ADDR_W  address of the instruction following the branch (return address)
jump_addr  out  ADDR_W  redirect target to fetch
jump_flag  out  1  one-cycle redirect strobe to fetch
flush  out  1  kill in-flight instructions in decode/execute
ras_overflow  out  1  sticky: CALL issued with RAS full
ras_underflow  out  1  sticky: RET issued with RAS empty
ras_level  out  $clog2(RAS_DEPTH)+1  current RAS occupancy

Behaviour:
- Reset (rst=0, async): jump_flag=0, jump_addr=0, flush=0, ras_overflow=0, ras_underflow=0, ras_level=0, FSM=IDLE, RAS pointer=0. Reset mid-flush aborts the flush immediately.
- Flow modes: NONE (never taken); JMP (always, target=address); BEZ (taken if alu_result==0); BNEZ (taken if alu_result!=0); BEQ (taken if alu_result==0, ALU performed subtract); BLTZ (taken if alu_result[DATA_W-1]==1); CALL (always, push pc_next, target=address); RET (pop, target=popped value). Unlisted encodings behave as NONE.
- Decision is evaluated only when valid_in=1 and FSM=IDLE. Latency: decision at edge N -> jump_flag=1 and jump_addr=target during cycle N+1, for exactly one cycle. jump_addr holds its last value when jump_flag=0.
- Not-taken branches: no outputs change, no flush.
- FSM IDLE -> FLUSH on a taken decision. flush=1 during FLUSH_CYCLES consecutive cycles starting in the same cycle as jump_flag. FLUSH -> IDLE when the down-counter reaches 0. In FLUSH, valid_in is ignored: no decision and no RAS push/pop for killed instructions.
- RAS: circular buffer. Push writes pc_next and increments the pointer. Pop decrements the pointer and reads that entry. ras_level saturates at RAS_DEPTH and at 0.
- CALL with RAS full: oldest entry overwritten (pointer wraps), ras_level stays RAS_DEPTH, ras_overflow set; the jump is still taken.
- RET with RAS empty: not taken, no flush, pointer unchanged, ras_underflow set.
- Sticky flags clear only on reset.
- Only one flow instruction per cycle, so push and pop never occur together.

Decomposition:
- Shared package/definitions file holds: FLOW_NONE=0, FLOW_JMP=1, FLOW_BEZ=2, FLOW_BNEZ=3, FLOW_BEQ=4, FLOW_BLTZ=5, FLOW_CALL=6, FLOW_RET=7, the flow_mode width (4), and the FSM state encodings IDLE/FLUSH.
- One sub-module: dsp_ras (parametrised LIFO with push/pop, wrap-on-full, level, overflow/underflow flags). The condition evaluation, FSM and flush counter stay in dsp_branch_unit.

Test Plan:
- Reset then BEZ with alu_result=0, address=0x0040, valid_in=1 -> next cycle jump_flag=1, jump_addr=0x0040; flush=1 for 2 cycles; then IDLE.
- BNEZ with alu_result=0 -> jump_flag stays 0, flush stays 0. BLTZ with alu_result=0x8001 -> taken. BLTZ with 0x7FFF -> not taken.
- Taken JMP to 0x0100, then BEZ (alu_result=0) presented during both flush cycles -> no second jump_flag. The same BEZ presented after flush -> taken.
- CALL x5 with RAS_DEPTH=4 and pc_next=0x10..0x14 -> ras_overflow=1, ras_level=4. Four RETs (spaced past flush) return 0x14, 0x13, 0x12, 0x11. A fifth RET -> no jump_flag, ras_underflow=1.
- Assert rst=0 asynchronously in the first flush cycle after a CALL -> flush, jump_flag and ras_level drop to 0 immediately without waiting for a clock. After release, RET -> underflow.
- Undefined flow_mode 0xF with valid_in=1 -> no jump, no flush, RAS unchanged.
